// File: rtl/fifo_pkg.sv
// Shared FIFO/packer definitions.
// Default geometry matches the syncFIFO_v2 instances.
package fifo_pkg;

  typedef enum logic {
    ST_FILL,
    ST_FLUSH
  } pack_state_t;

  localparam int FIFO_WIDTH = 4;
  localparam int PACK_RATIO = 4;

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO-side and word-side bundle for the packer.
// master = packer, slave = FIFO/consumer environment.
interface fifo_word_packer_if #(
  parameter int WIDTH = 4,
  parameter int RATIO = 4
);
  localparam int CNT_W = $clog2(RATIO + 1);

  logic [WIDTH-1:0]       i_fifo_data;
  logic                   i_fifo_empty;
  logic                   o_fifo_rd_en;
  logic                   i_flush;
  logic [WIDTH*RATIO-1:0] o_data;
  logic                   o_valid;
  logic [CNT_W-1:0]       o_count;
  logic                   i_ready;

  modport master (
    input  i_fifo_data,
    input  i_fifo_empty,
    input  i_flush,
    input  i_ready,
    output o_fifo_rd_en,
    output o_data,
    output o_valid,
    output o_count
  );

  modport slave (
    output i_fifo_data,
    output i_fifo_empty,
    output i_flush,
    output i_ready,
    input  o_fifo_rd_en,
    input  o_data,
    input  o_valid,
    input  o_count
  );

endinterface

// File: rtl/fifo_word_packer.sv
// Packs RATIO show-ahead FIFO entries into one word,
// first entry in the LSBs; flush emits a partial word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int RATIO = PACK_RATIO,
  parameter int CNT_W = $clog2(RATIO + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  fifo_word_packer_if.master bus
);

  localparam int LC_W  = $clog2(RATIO);
  localparam int ACC_W = WIDTH * (RATIO - 1);
  localparam int OUT_W = WIDTH * RATIO;

  pack_state_t      r_state;
  pack_state_t      w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [LC_W-1:0]  r_lane_cnt;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] w_part;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             w_out_busy;
  logic             w_last;
  logic             w_rd_en;
  logic             w_flush_emit;

  assign w_out_busy = r_valid && !bus.i_ready;
  assign w_last     = (r_lane_cnt == LC_W'(RATIO - 1));

  // Final lane is withheld while the output is stalled.
  assign w_rd_en = (r_state == ST_FILL) && !bus.i_fifo_empty
                && !(w_last && w_out_busy);

  assign w_flush_emit = (r_state == ST_FLUSH)
                     && (r_lane_cnt != '0) && !w_out_busy;

  assign bus.o_fifo_rd_en = w_rd_en;
  assign bus.o_data       = r_data;
  assign bus.o_valid      = r_valid;
  assign bus.o_count      = r_count;

  // Lane write into the accumulator and zero-padded partial word.
  always_comb begin
    w_acc_nxt = r_acc;
    w_part    = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (w_rd_en && !w_last && r_lane_cnt == LC_W'(k))
        w_acc_nxt[k*WIDTH +: WIDTH] = bus.i_fifo_data;
      if (LC_W'(k) < r_lane_cnt)
        w_part[k*WIDTH +: WIDTH] = r_acc[k*WIDTH +: WIDTH];
    end
  end

  // Flush FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FILL: begin
        if (bus.i_flush)
          w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_lane_cnt == '0 || !w_out_busy)
          w_state_nxt = ST_FILL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_FILL;
    else       r_state <= w_state_nxt;
  end

  // Accumulator and lane counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc      <= '0;
      r_lane_cnt <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      if (w_rd_en)
        r_lane_cnt <= w_last ? '0 : r_lane_cnt + LC_W'(1);
      else if (w_flush_emit)
        r_lane_cnt <= '0;
    end
  end

  // Output register; a load may replace an accepted word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (w_rd_en && w_last) begin
      r_data  <= {bus.i_fifo_data, r_acc};
      r_count <= CNT_W'(RATIO);
      r_valid <= 1'b1;
    end else if (w_flush_emit) begin
      r_data  <= w_part;
      r_count <= CNT_W'(r_lane_cnt);
      r_valid <= 1'b1;
    end else if (r_valid && bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  a_no_pop_empty : assert property (
    @(posedge i_clk) disable iff (i_rst)
    !(w_rd_en && bus.i_fifo_empty));

  a_hold_busy : assert property (
    @(posedge i_clk) disable iff (i_rst)
    w_out_busy |=> ($stable(r_data) && $stable(r_count)));

  a_count_nz : assert property (
    @(posedge i_clk) disable iff (i_rst)
    r_valid |-> (r_count != '0));

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer, WIDTH=4 RATIO=4.
// Queue-based FIFO model, scoreboard and word monitor.
module tb_fifo_word_packer;
  import fifo_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] fq[$];
  exp_t       exp_q[$];

  fifo_word_packer_if #(.WIDTH(4), .RATIO(4)) bus();

  fifo_word_packer #(.WIDTH(4), .RATIO(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fifo_refresh();
    if (fq.size() > 0) begin
      bus.i_fifo_data  = fq[0];
      bus.i_fifo_empty = 1'b0;
    end else begin
      bus.i_fifo_data  = '0;
      bus.i_fifo_empty = 1'b1;
    end
  endtask

  task automatic push(logic [3:0] v);
    fq.push_back(v);
    fifo_refresh();
  endtask

  task automatic expect_word(logic [15:0] d, logic [2:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still pending, required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  // FIFO model pops on the same edge as rd_en.
  always @(posedge clk) begin
    if (bus.o_fifo_rd_en) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: rd_en=1 while FIFO empty");
      end else begin
        void'(fq.pop_front());
      end
      #1 fifo_refresh();
    end
  end

  // Monitor: compare each accepted word against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data=%h count=%0d, required none",
                 bus.o_data, bus.o_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", 32'(bus.o_data), 32'(e.d));
        chk("word_count", 32'(bus.o_count), 32'(e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    fifo_refresh();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data", 32'(bus.o_data), 0);
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_rd_en", 32'(bus.o_fifo_rd_en), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: one full word at full rate
    @(negedge clk);
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    expect_word(16'h4321, 3'd4);
    for (int i = 0; i < 4; i++) begin
      #2 chk("t1_rd_en", 32'(bus.o_fifo_rd_en), 1);
      @(negedge clk);
    end
    #2;
    chk("t1_rd_en_done", 32'(bus.o_fifo_rd_en), 0);
    chk("t1_valid", 32'(bus.o_valid), 1);
    @(negedge clk);
    #2 chk("t1_valid_drop", 32'(bus.o_valid), 0);
    drain();

    // 2: backpressure holds the final lane
    @(negedge clk);
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    expect_word(16'h4321, 3'd4);
    expect_word(16'h8765, 3'd4);
    repeat (10) @(negedge clk);
    #2;
    chk("t2_rd_en_held", 32'(bus.o_fifo_rd_en), 0);
    chk("t2_fifo_left", 32'(fq.size()), 1);
    chk("t2_valid", 32'(bus.o_valid), 1);
    chk("t2_data_held", 32'(bus.o_data), 32'h4321);
    @(negedge clk);
    bus.i_ready = 1'b1;
    #2 chk("t2_rd_en_free", 32'(bus.o_fifo_rd_en), 1);
    @(negedge clk);
    #2;
    chk("t2_b2b_valid", 32'(bus.o_valid), 1);
    chk("t2_b2b_data", 32'(bus.o_data), 32'h8765);
    drain();

    // 3: flush of a two-lane partial word
    @(negedge clk);
    push(4'hA); push(4'hB);
    expect_word(16'h00BA, 3'd2);
    repeat (3) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    drain();
    @(negedge clk);
    #2 chk("t3_lane_cnt", 32'(dut.r_lane_cnt), 0);

    // 4a: flush with nothing held
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    #2 chk("t4_no_valid", 32'(bus.o_valid), 0);
    @(negedge clk);
    #2;
    chk("t4_state", 32'(dut.r_state), 32'(ST_FILL));
    chk("t4_no_valid2", 32'(bus.o_valid), 0);

    // 4b: flush coinciding with the final pop
    @(negedge clk);
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    expect_word(16'h4321, 3'd4);
    repeat (3) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    #2;
    chk("t4b_state", 32'(dut.r_state), 32'(ST_FILL));
    chk("t4b_lane_cnt", 32'(dut.r_lane_cnt), 0);

    // 5: idle on empty FIFO, then a word
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      chk("t5_idle_rd_en", 32'(bus.o_fifo_rd_en), 0);
      chk("t5_idle_valid", 32'(bus.o_valid), 0);
    end
    @(negedge clk);
    push(4'hC); push(4'hD); push(4'hE); push(4'hF);
    expect_word(16'hFEDC, 3'd4);
    drain();

    // 6: async reset with three lanes held
    @(negedge clk);
    push(4'h1); push(4'h2); push(4'h3);
    repeat (3) @(negedge clk);
    #1 chk("t6_pre_lane_cnt", 32'(dut.r_lane_cnt), 3);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.o_valid), 0);
    chk("t6_rst_count", 32'(bus.o_count), 0);
    chk("t6_rst_lane_cnt", 32'(dut.r_lane_cnt), 0);
    chk("t6_rst_data", 32'(bus.o_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(4'h5); push(4'h6); push(4'h7); push(4'h8);
    expect_word(16'h8765, 3'd4);
    drain();

    repeat (5) @(negedge clk);
    chk("final_fifo_empty", 32'(fq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Downstream consumer of the synchronous FIFO (show-ahead, combinational read data). It pops WIDTH-bit entries and packs RATIO consecutive entries into one WIDTH*RATIO-bit word, first-popped entry in the LSBs. Words are presented on a registered valid/ready output. A flush request emits a partial word with a lane count. Full throughput is one word per RATIO cycles under no backpressure.

Parameters:
WIDTH, 4, bit width of one FIFO entry (lane)
RATIO, 4, lanes per output word; legal range is RATIO >= 2
CNT_W, $clog2(RATIO+1), width of o_count (derived; do not override)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_fifo_data  in  WIDTH  FIFO head entry; valid whenever i_fifo_empty=0
i_fifo_empty  in  1  FIFO empty flag
o_fifo_rd_en  out  1  pop strobe; FIFO advances on the same rising edge
i_flush  in  1  single-cycle request to emit the held partial word
o_data  out  WIDTH*RATIO  packed word; lane k occupies bits [k*WIDTH +: WIDTH]
o_valid  out  1  o_data/o_count valid
o_count  out  CNT_W  number of valid lanes in o_data (1..RATIO)
i_ready  in  1  consumer accepts the word when o_valid && i_ready

Behaviour:
- Reset (async, i_rst=1): o_valid=0, o_data=0, o_count=0, lane_cnt=0, acc=0, state=ST_FILL. Any partial word is discarded.
- Internal state: accumulator acc (RATIO-1 lanes); lane_cnt in 0..RATIO-1; 2-state FSM {ST_FILL, ST_FLUSH}.
- out_busy = o_valid && !i_ready.
- last = (lane_cnt == RATIO-1).
- o_fifo_rd_en is combinational: (state==ST_FILL) && !i_fifo_empty && !(last && out_busy).
  - It is never asserted while the FIFO is empty.
- Pop with !last: acc lane[lane_cnt] <= i_fifo_data; lane_cnt increments.
- Pop with last:
  - o_data <= {i_fifo_data, acc}; o_count <= RATIO; o_valid <= 1; lane_cnt <= 0.
  - Latency: word is visible the cycle after the final pop.
- Output register:
  - If o_valid && i_ready and there is no new load, o_valid <= 0.
  - A load overwrites in the same cycle as acceptance, giving back-to-back words.
  - o_data and o_count hold stable while out_busy.
- FSM:
  - ST_FILL, i_flush=1 -> ST_FLUSH.
    - A pop in that same cycle still completes normally.
    - If that pop completes a word, lane_cnt becomes 0 and the flush emits nothing.
  - ST_FLUSH, no pops:
    - lane_cnt==0 -> ST_FILL, no output.
    - lane_cnt>0 and !out_busy -> o_data <= acc, with unused upper lanes set to 0; o_count <= lane_cnt; o_valid <= 1; lane_cnt <= 0; -> ST_FILL.
    - lane_cnt>0 and out_busy -> stay in ST_FLUSH.
  - i_flush while in ST_FLUSH is ignored.
- Wrap-around: lane_cnt returns to 0 after the final lane; there is no other modulo arithmetic.
- Simultaneous final pop and output acceptance is a legal full-rate case.
- Simultaneous final pop while out_busy: the pop is withheld (rd_en=0) until the output frees.
- Reset mid-operation: all state clears immediately. After release, the next popped entry lands in lane 0.

Decomposition:
- Shared package fifo_pkg holds:
  - typedef enum logic {ST_FILL, ST_FLUSH} pack_state_t
  - default constants FIFO_WIDTH=4, PACK_RATIO=4, shared with syncFIFO_v2 instantiations
- Single module; no sub-module is needed.
- Bind-style concurrent assertions live in the same file, mirroring the FIFO's assertion set:
  - no pop when empty
  - o_data/o_count stable while out_busy
  - o_count never 0 when o_valid

Test Plan (WIDTH=4, RATIO=4):
1. FIFO holds 1,2,3,4; i_ready=1 -> rd_en high 4 consecutive cycles; next cycle o_valid=1, o_data=16'h4321, o_count=4 for one cycle.
2. FIFO holds 1..8; i_ready=0 -> 16'h4321 held stable; pops of 5,6,7 occur; 8 is not popped (rd_en=0). Raise i_ready -> 8 pops that cycle; 16'h8765 follows immediately with o_valid staying high.
3. Push A,B, FIFO then empty; pulse i_flush -> one cycle later o_valid=1, o_data=16'h00BA, o_count=2; lane_cnt=0 after.
4. i_flush with lane_cnt=0 -> no o_valid; state returns to ST_FILL next cycle. i_flush in the same cycle as the 4th pop of 1..4 -> only 16'h4321/count 4 is emitted.
5. FIFO empty for 20 cycles -> o_fifo_rd_en stays 0 and o_valid stays 0. Then push C,D,E,F -> 16'hFEDC.
6. Accumulate 1,2,3, assert i_rst mid-cycle -> o_valid, o_count, lane_cnt read 0 immediately. After release, push 5,6,7,8 -> 16'h8765 (no stale lanes).
